// File: rtl/mul_seq_32.sv
// Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH bits.
// Latency: done pulses WIDTH+1 edges after the accepting edge; one op in flight at a time.
// Backpressure: start is only sampled in IDLE or DONE; it is ignored while busy.
// Optional macro MUL_SIGNED_EN: two's-complement operands via magnitude multiply plus sign fix-up.
module mul_seq_32 #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     add_op;
  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;

  // Operand magnitudes and final product as seen by the datapath
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   acc_full, result;

  assign acc_full = {acc_hi_q, acc_lo_q};

`ifdef MUL_SIGNED_EN
  logic neg_q, neg_d;

  // Most-negative input maps to magnitude 2^(WIDTH-1), which still fits unsigned
  assign a_mag  = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag  = b[WIDTH-1] ? (~b + 1'b1) : b;
  assign result = neg_q ? (~acc_full + 1'b1) : acc_full;

  // Sign of the result, latched with the operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) neg_q <= 1'b0;
    else        neg_q <= neg_d;
  end

  // Sign only changes when a new request is accepted
  always_comb begin
    neg_d = neg_q;
    if (start && (state_q == IDLE || state_q == DONE))
      neg_d = a[WIDTH-1] ^ b[WIDTH-1];
  end
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign result = acc_full;
`endif

  // Ripple-carry adder: acc_hi plus mcand when the current multiplier bit is set
  always_comb begin : rca
    logic c;
    add_op  = acc_lo_q[0] ? mcand_q : '0;
    add_sum = '0;
    c       = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      add_sum[i] = acc_hi_q[i] ^ add_op[i] ^ c;
      c          = (acc_hi_q[i] & add_op[i]) | (c & (acc_hi_q[i] ^ add_op[i]));
    end
    add_cout = c;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  // Next-state, datapath update and status outputs
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    count_d   = count_q;
    product_d = product_q;
    busy      = (state_q == CALC);
    done      = (state_q == DONE);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = CALC;
          mcand_d  = a_mag;
          acc_lo_d = b_mag;
          acc_hi_d = '0;
          count_d  = '0;
        end else begin
          state_d  = IDLE;
        end
      end
      CALC: begin
        if (count_q == CW'(WIDTH)) begin
          // All multiplier bits consumed; publish the accumulator
          state_d   = DONE;
          product_d = result;
        end else begin
          // Carry-out becomes the top bit as the accumulator shifts right
          {acc_hi_d, acc_lo_d} = {add_cout, add_sum, acc_lo_q[WIDTH-1:1]};
          count_d              = count_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign product = product_q;

endmodule

// File: tb/tb_mul_seq_32.sv
// Self-checking bench for mul_seq_32: directed corner cases plus random operands
// against an arithmetic reference model; covers reset, back-to-back and mid-op abort.
module tb_mul_seq_32;

  localparam int W = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [W-1:0]    a = '0;
  logic [W-1:0]    b = '0;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  product;

  int n_checks = 0;
  int n_errors = 0;

  mul_seq_32 #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic product of the operands
  function automatic logic [63:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef MUL_SIGNED_EN
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return 64'(sx * sy);
`else
    return {32'b0, x} * {32'b0, y};
`endif
  endfunction

  // Issue one operation (block must be in IDLE or DONE) and wait for its done pulse.
  // If poke_at > 0, a stray start with other operands is pulsed at that CALC cycle.
  task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input int poke_at);
    logic [63:0] exp;
    int n;
    int overlap;
    exp   = model(xa, xb);
    start = 1'b1;
    a     = xa;
    b     = xb;
    @(posedge clk); #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    check({tag, " busy_after_accept"}, 64'(busy), 64'd1);
    n       = 0;
    overlap = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (busy && done) overlap++;
      if (n == poke_at) begin
        start = 1'b1;
        a     = 32'd2;
        b     = 32'd2;
      end
    end
    check({tag, " latency"}, 64'(n), 64'(W + 1));
    check({tag, " product"}, product, exp);
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    check({tag, " busy_done_overlap"}, 64'(overlap), 64'd0);
  endtask

  // Leave DONE without a new request; done must drop and product must hold
  task automatic go_idle(input string tag, input logic [63:0] exp);
    start = 1'b0;
    @(posedge clk); #1;
    check({tag, " done_pulse_width"}, 64'(done), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, " product_hold"}, product, exp);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int seen;

    // Reset, then ten quiet cycles
    #12;
    check("reset product", product, 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle outputs", {product[61:0], busy, done}, 64'd0);
    end

    run_op("3x5", 32'd3, 32'd5, 0);
    go_idle("3x5", model(32'd3, 32'd5));

    run_op("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    go_idle("ffxff", model(32'hFFFF_FFFF, 32'hFFFF_FFFF));

    run_op("m3x7", 32'hFFFF_FFFD, 32'd7, 0);
    run_op("minxmin", 32'h8000_0000, 32'h8000_0000, 0);
    run_op("zero", 32'd0, 32'hDEAD_BEEF, 0);
    go_idle("zero", 64'd0);

    // Stray start during CALC is ignored; new request in DONE is accepted
    run_op("6x7", 32'd6, 32'd7, 10);
    run_op("9x9", 32'd9, 32'd9, 0);
    go_idle("9x9", 64'd81);

    // Abort mid-operation
    start = 1'b1; a = 32'd100; b = 32'd100;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort outputs", {product[61:0], busy, done}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("abort no_done", 64'(seen), 64'd0);
    run_op("4x4", 32'd4, 32'd4, 0);
    go_idle("4x4", 64'd16);

    // Random operands, mixing back-to-back and idle gaps
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) ra = {ra[W-1], {(W-1){~ra[W-1]}}};
      run_op("random", ra, rb, (i % 3 == 0) ? int'($urandom_range(1, 31)) : 0);
      if ($urandom_range(0, 1) == 1) go_idle("random", model(ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
